// File: rtl/dtc_pkg.sv
// dtc_pkg: shared types and constants for the decision-tree classifier scheduler.
// Holds the FSM state encoding, default feature width and requester-index type.
package dtc_pkg;

  localparam int DTC_FEAT_W  = 12;
  localparam int DTC_NUM_REQ = 4;
  localparam int DTC_IDX_W   = $clog2(DTC_NUM_REQ);
  localparam int DTC_LAT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_RESP
  } dtc_state_e;

  typedef logic [DTC_IDX_W-1:0] dtc_idx_t;

  // Index width that stays legal for a single requester.
  function automatic int dtc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dtc_rr_arb.sv
// dtc_rr_arb: round-robin arbiter for the classifier scheduler.
// Scans requests starting at ptr_i and returns one-hot grant plus its index.
module dtc_rr_arb
  import dtc_pkg::*;
#(
  parameter  int NUM_REQ = DTC_NUM_REQ,
  localparam int IDX_W   = dtc_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               any_o
);

  // First requester at or after the pointer wins, wrapping past the top.
  always_comb begin
    int  idx;
    logic found;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IDX_W'(idx);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/dtc_sched.sv
// dtc_sched: shares one external decision tree among NUM_REQ requesters.
// Optional per-requester class-1 counters are built when DTC_SCHED_STATS_EN is defined.
module dtc_sched
  import dtc_pkg::*;
#(
  parameter  int NUM_REQ  = DTC_NUM_REQ,
  parameter  int FEAT_W   = DTC_FEAT_W,
  parameter  int TREE_LAT = 1,
  parameter  int CNT_W    = 16,
  localparam int IDX_W    = dtc_idx_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*FEAT_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [FEAT_W-1:0]        tree_inp,
  input  logic                     tree_outp,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDX_W-1:0]         rsp_id,
  output logic                     rsp_class,
  input  logic                     stat_clr,
  output logic [NUM_REQ*CNT_W-1:0] stat_pos_cnt
);

  dtc_state_e             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       id_q, id_d;
  logic [DTC_LAT_W-1:0]   cnt_q, cnt_d;
  logic [FEAT_W-1:0]      feat_q, feat_d;
  logic                   vld_q, vld_d;
  logic                   cls_q, cls_d;

  logic [NUM_REQ-1:0]     gnt;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   gnt_any;
  logic                   rsp_hs;

  dtc_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  assign req_ready = (state_q == ST_IDLE && !rst) ? gnt : '0;
  assign tree_inp  = feat_q;
  assign rsp_valid = vld_q;
  assign rsp_id    = id_q;
  assign rsp_class = cls_q;
  assign rsp_hs    = vld_q && rsp_ready;

  // Next-state logic: accept in IDLE, count down the tree latency, hold the result.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    feat_d  = feat_q;
    vld_d   = vld_q;
    cls_d   = cls_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          feat_d  = req_data[gnt_idx*FEAT_W +: FEAT_W];
          id_d    = gnt_idx;
          cnt_d   = DTC_LAT_W'(TREE_LAT);
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == DTC_LAT_W'(1)) begin
          cls_d   = tree_outp;
          vld_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          vld_d   = 1'b0;
          ptr_d   = (id_q == IDX_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scheduler state; reset drops any sample that is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      feat_q  <= '0;
      vld_q   <= 1'b0;
      cls_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      feat_q  <= feat_d;
      vld_q   <= vld_d;
      cls_q   <= cls_d;
    end
  end

`ifdef DTC_SCHED_STATS_EN
  logic [NUM_REQ*CNT_W-1:0] stat_q, stat_d;

  // Saturating class-1 counters; a clear beats a same-cycle increment.
  always_comb begin
    stat_d = stat_q;
    if (stat_clr) begin
      stat_d = '0;
    end else if (rsp_hs && cls_q) begin
      if (stat_q[id_q*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
        stat_d[id_q*CNT_W +: CNT_W] = stat_q[id_q*CNT_W +: CNT_W] + 1'b1;
      end
    end
  end

  // Counter storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_pos_cnt = stat_q;
`else
  logic stat_unused;

  assign stat_unused  = stat_clr ^ rsp_hs;
  assign stat_pos_cnt = '0;
`endif

endmodule

// File: tb/tb_dtc_sched.sv
// tb_dtc_sched: directed self-checking bench for dtc_sched.
// Drives a simple combinational tree model and checks arbitration, latency and reset.
module tb_dtc_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [47:0] req_data;
  logic [3:0]  req_ready;
  logic [11:0] tree_inp;
  logic        tree_outp;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic        rsp_class;
  logic        stat_clr;
  logic [15:0] stat_pos_cnt;

  logic [3:0]  v15;
  logic [47:0] d15;
  logic [3:0]  rdy15;
  logic [11:0] inp15;
  logic        outp15;
  logic        vld15;
  logic        rr15;
  logic [1:0]  id15;
  logic        cls15;
  logic [15:0] stat15;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic tree_f(input logic [11:0] f);
    return (f[11:8] > 4'd3) ? f[0] : f[5];
  endfunction

  assign tree_outp = tree_f(tree_inp);
  assign outp15    = tree_f(inp15);

  dtc_sched #(
    .NUM_REQ  (4),
    .FEAT_W   (12),
    .TREE_LAT (1),
    .CNT_W    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .tree_inp     (tree_inp),
    .tree_outp    (tree_outp),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_class    (rsp_class),
    .stat_clr     (stat_clr),
    .stat_pos_cnt (stat_pos_cnt)
  );

  dtc_sched #(
    .NUM_REQ  (4),
    .FEAT_W   (12),
    .TREE_LAT (15),
    .CNT_W    (4)
  ) dut15 (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (v15),
    .req_data     (d15),
    .req_ready    (rdy15),
    .tree_inp     (inp15),
    .tree_outp    (outp15),
    .rsp_valid    (vld15),
    .rsp_ready    (rr15),
    .rsp_id       (id15),
    .rsp_class    (cls15),
    .stat_clr     (1'b0),
    .stat_pos_cnt (stat15)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    stat_clr  = 1'b0;
    v15       = '0;
    rr15      = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_one(input int idx, input logic [11:0] d);
    int n;
    req_data[idx*12 +: 12] = d;
    req_valid = 4'(1 << idx);
    rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (req_ready == 4'b0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("run_gnt", 32'(req_ready), 32'(1 << idx));
    @(posedge clk);
    #1 req_valid = '0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("run_rsp", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          t0;
    int          seen;
    int          ord[6];
    logic [11:0] dv[4];
    logic        cv[4];

    ord = '{0, 1, 2, 3, 0, 1};
    dv  = '{12'h400, 12'h0A5, 12'h501, 12'h010};
    cv  = '{1'b0, 1'b1, 1'b1, 1'b0};
    req_data = '0;
    d15      = '0;

    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    stat_clr  = 1'b0;
    v15       = '0;
    rr15      = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_outs", 32'({tree_inp, rsp_valid, rsp_id, rsp_class}), 32'd0);
    chk("rst_stat", 32'(stat_pos_cnt), 32'd0);

    // single request on requester 2
    do_reset();
    req_data[2*12 +: 12] = 12'h0A5;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("one_ready", 32'(req_ready), 32'h4);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("one_inp", 32'(tree_inp), 32'h0A5);
    chk("one_eval", 32'({rsp_valid, req_ready}), 32'd0);
    @(negedge clk);
    chk("one_rsp", 32'({rsp_valid, rsp_id, rsp_class}), 32'b1101);

    // consumer stalls while every requester asks
    req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall", 32'({rsp_valid, rsp_id, rsp_class, req_ready}), 32'hD0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk);
    chk("hs_vld", 32'(rsp_valid), 32'd0);
    chk("ptr_next", 32'(req_ready), 32'h8);
    req_valid = '0;

    // all requesters continuously valid
    do_reset();
    for (int i = 0; i < 4; i++) req_data[i*12 +: 12] = dv[i];
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    t0 = 0;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      @(negedge clk);
      while (req_ready == 4'b0 && n < 8) begin
        @(negedge clk);
        n++;
      end
      chk("rr_gnt", 32'(req_ready), 32'(1 << ord[g]));
      if (g > 0) chk("rr_gap", 32'(cyc - t0), 32'd3);
      t0 = cyc;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 8) begin
        @(negedge clk);
        n++;
      end
      chk("rr_id", 32'(rsp_id), 32'(ord[g]));
      chk("rr_cls", 32'(rsp_class), 32'(cv[ord[g]]));
    end
    @(posedge clk);
    #1 req_valid = '0;
`ifdef DTC_SCHED_STATS_EN
    chk("rr_stat", 32'(stat_pos_cnt), 32'h0120);
`else
    chk("rr_stat", 32'(stat_pos_cnt), 32'h0);
`endif

    // reset in the middle of an evaluation
    do_reset();
    req_data[3*12 +: 12] = 12'h010;
    req_valid = 4'b1000;
    @(negedge clk);
    chk("mid_ready", 32'(req_ready), 32'h8);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("mid_inp", 32'({tree_inp, rsp_id}), 32'({12'h010, 2'd3}));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_zero",
        32'({tree_inp, rsp_valid, rsp_id, rsp_class, req_ready}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("mid_norsp", 32'(seen), 32'd0);

    // long tree latency
    do_reset();
    d15[1*12 +: 12] = 12'h0A5;
    v15  = 4'b0010;
    rr15 = 1'b1;
    n = 0;
    @(negedge clk);
    while (rdy15 == 4'b0 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("l15_gnt", 32'(rdy15), 32'h2);
    t0 = cyc;
    @(posedge clk);
    #1 v15 = '0;
    n = 0;
    @(negedge clk);
    while (!vld15 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("l15_lat", 32'(cyc - t0), 32'd16);
    chk("l15_rsp", 32'({vld15, id15, cls15}), 32'b1011);
    @(posedge clk);
    #1 rr15 = 1'b0;
`ifdef DTC_SCHED_STATS_EN
    chk("l15_stat", 32'(stat15), 32'h0010);
`else
    chk("l15_stat", 32'(stat15), 32'h0);
`endif

`ifdef DTC_SCHED_STATS_EN
    // saturation and clear priority
    do_reset();
    for (int i = 0; i < 20; i++) run_one(1, 12'h0A5);
    chk("sat", 32'(stat_pos_cnt), 32'h00F0);
    req_data[1*12 +: 12] = 12'h0A5;
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = '0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("clr_rsp", 32'({rsp_valid, rsp_class}), 32'b11);
    stat_clr  = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    stat_clr  = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("clr_prio", 32'(stat_pos_cnt), 32'h0);
    run_one(1, 12'h0A5);
    chk("clr_inc", 32'(stat_pos_cnt), 32'h0010);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dtc_sched.md
DTC_SCHED -- requirements
Module: dtc_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one classifier.
REQ-002 Parameter FEAT_W, default 12, feature-vector width presented to the tree.
REQ-003 Parameter TREE_LAT, default 1, cycles from driving tree_inp to sampling tree_outp (range 1..15).
REQ-004 Parameter CNT_W, default 16, width of the statistics counters.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  NUM_REQ  per-requester sample valid.
REQ-008 req_data  input  NUM_REQ*FEAT_W  per-requester feature vectors; requester i occupies bits [i*FEAT_W +: FEAT_W].
REQ-009 req_ready  output  NUM_REQ  one-hot accept strobe for the granted requester.
REQ-010 tree_inp  output  FEAT_W  registered feature vector to the shared tree.
REQ-011 tree_outp  input  1  tree class decision.
REQ-012 rsp_valid  output  1  result valid.
REQ-013 rsp_ready  input  1  result consumer ready.
REQ-014 rsp_id  output  $clog2(NUM_REQ)  index of the requester that owns the result.
REQ-015 rsp_class  output  1  classification result.
REQ-016 stat_clr  input  1  synchronous clear of the statistics counters.
REQ-017 stat_pos_cnt  output  NUM_REQ*CNT_W  per-requester count of class-1 results.

Function
REQ-018 FSM states: IDLE, EVAL, RESP.
REQ-019 IDLE: if any req_valid is set, grant round-robin starting at pointer ptr, pulse req_ready[grant] for one cycle, load tree_inp with that requester's data, load wait counter with TREE_LAT, and go to EVAL.
REQ-020 IDLE with no req_valid: remain in IDLE; req_ready stays all-zero.
REQ-021 EVAL: decrement the wait counter each cycle; in the cycle it reaches zero, register tree_outp into rsp_class, set rsp_valid, and go to RESP.
REQ-022 RESP: hold rsp_valid, rsp_id and rsp_class stable until rsp_valid && rsp_ready; on that edge clear rsp_valid, set ptr = (grant+1) mod NUM_REQ, and return to IDLE.
REQ-023 tree_inp holds its value from acceptance until the next grant.
REQ-024 req_ready is asserted only in IDLE, so at most one sample is in flight; minimum issue interval is TREE_LAT+2 cycles.
REQ-025 A requester that drops req_valid before being granted loses nothing; no sample is latched without a req_ready pulse.
REQ-026 Wrap-around: ptr wraps from NUM_REQ-1 to 0; with all requesters valid, grants rotate 0,1,2,3,0.

Reset
REQ-027 Reset forces the FSM to IDLE, ptr to 0, and req_ready, rsp_valid, rsp_id, rsp_class and tree_inp to 0, and clears all statistics counters.
REQ-028 Reset asserted mid-EVAL or mid-RESP abandons the in-flight sample; no response is produced after reset release.

Configuration
REQ-029 Macro DTC_SCHED_STATS_EN defined: on each response handshake with rsp_class=1, stat_pos_cnt[rsp_id] increments and saturates at 2^CNT_W-1; stat_clr has priority over a same-cycle increment.
REQ-030 Macro DTC_SCHED_STATS_EN undefined: stat_pos_cnt is tied to 0, stat_clr is ignored, and no counter flops are built.

Structure
REQ-031 The shared package dtc_pkg holds the FSM state enum, DTC_FEAT_W=12, and the requester-index typedef.
REQ-032 The round-robin arbiter is one sub-module, dtc_rr_arb (inputs: request vector and ptr; output: one-hot grant plus grant index).
REQ-033 The tree is instantiated outside this block; dtc_sched only drives tree_inp and samples tree_outp.

Verification
REQ-034 After reset, a single req_valid[2] with data 12'h0A5 and TREE_LAT=1 -> req_ready[2] pulses in cycle 1; tree_inp=12'h0A5; rsp_valid rises in cycle 3 with rsp_id=2 and rsp_class equal to the model tree output.
REQ-035 All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1; each requester is served once per 4 responses.
REQ-036 rsp_ready held 0 for 10 cycles during RESP -> rsp_valid, rsp_id and rsp_class stay stable; no req_ready pulses during that time.
REQ-037 rst asserted while in EVAL -> all outputs are 0 in the next cycle; with no requests pending, no rsp_valid follows reset release.
REQ-038 With DTC_SCHED_STATS_EN and CNT_W=4, 20 class-1 results for requester 1 -> stat_pos_cnt[1]=15 (saturated); stat_clr pulsed together with an increment -> counter reads 0.
REQ-039 TREE_LAT=15 -> rsp_valid rises exactly 16 cycles after the req_ready pulse.
